// File: rtl/jacobi_iter_ctrl_if.sv
// Host / detector / sweep-datapath signals of the Jacobi iteration sequencer.
// The master side is the environment that drives the inputs; the slave side is the sequencer.
interface jacobi_iter_ctrl_if #(
  parameter int unsigned ITER_W = 8
);
  logic              start;
  logic              abort;
  logic              iter_done;
  logic              conv_ok;
  logic              calc_enable;
  logic              sweep_start;
  logic              buf_sel;
  logic [ITER_W-1:0] iter_count;
  logic              busy;
  logic              done;
  logic              converged;
  logic              timeout;

  modport master (
    output start, abort, iter_done, conv_ok,
    input  calc_enable, sweep_start, buf_sel, iter_count, busy, done, converged, timeout
  );

  modport slave (
    input  start, abort, iter_done, conv_ok,
    output calc_enable, sweep_start, buf_sel, iter_count, busy, done, converged, timeout
  );
endinterface

// File: rtl/jacobi_iter_ctrl.sv
// Jacobi sweep sequencer: launches sweeps, gates the completion detector, counts
// iterations, flips the X ping-pong bank and stops on convergence, limit or abort.
module jacobi_iter_ctrl #(
  parameter int unsigned ITER_W       = 8,
  parameter int unsigned MAX_ITER     = 100,
  parameter int unsigned FLUSH_CYCLES = 14
) (
  input  logic               clock,
  input  logic               reset,
  jacobi_iter_ctrl_if.slave  bus
);

  localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    CHECK  = 3'd3,
    FLUSH  = 3'd4,
    FINISH = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [ITER_W-1:0]  iter_count_q, iter_count_d;
  logic [ITER_W-1:0]  iter_next;
  logic               at_limit;
  logic               calc_enable_q, calc_enable_d;
  logic               sweep_start_q, sweep_start_d;
  logic               buf_sel_q, buf_sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               converged_q, converged_d;
  logic               timeout_q, timeout_d;

  assign iter_next = iter_count_q + ITER_W'(1);
  assign at_limit  = (iter_next == ITER_W'(MAX_ITER));

  // State register and flush counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic; abort overrides every decision outside IDLE
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    unique case (state_q)
      IDLE:   if (bus.start && !bus.abort) state_d = LAUNCH;
      LAUNCH: state_d = RUN;
      RUN:    if (bus.iter_done) state_d = CHECK;
      CHECK: begin
        if (bus.conv_ok || at_limit) begin
          state_d = FINISH;
        end else begin
          state_d = FLUSH;
          flush_d = FLUSH_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (flush_q == '0) state_d = LAUNCH;
        else               flush_d = flush_q - FLUSH_W'(1);
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) state_d = IDLE;
  end

  // Output logic: strobes are decoded from the next state so they line up with it
  always_comb begin
    iter_count_d  = iter_count_q;
    buf_sel_d     = buf_sel_q;
    converged_d   = converged_q;
    timeout_d     = timeout_q;
    calc_enable_d = (state_d == LAUNCH) || (state_d == RUN);
    sweep_start_d = (state_d == LAUNCH);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == FINISH);

    if (state_q == IDLE && state_d == LAUNCH) begin
      iter_count_d = '0;
      buf_sel_d    = 1'b0;
      converged_d  = 1'b0;
      timeout_d    = 1'b0;
    end

    // An abort during CHECK leaves count and bank untouched
    if (state_q == CHECK && state_d != IDLE) begin
      iter_count_d = iter_next;
      buf_sel_d    = ~buf_sel_q;
      if (state_d == FINISH) begin
        converged_d = bus.conv_ok;
        timeout_d   = ~bus.conv_ok;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      iter_count_q  <= '0;
      buf_sel_q     <= 1'b0;
      converged_q   <= 1'b0;
      timeout_q     <= 1'b0;
      calc_enable_q <= 1'b0;
      sweep_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      iter_count_q  <= iter_count_d;
      buf_sel_q     <= buf_sel_d;
      converged_q   <= converged_d;
      timeout_q     <= timeout_d;
      calc_enable_q <= calc_enable_d;
      sweep_start_q <= sweep_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.calc_enable = calc_enable_q;
  assign bus.sweep_start = sweep_start_q;
  assign bus.buf_sel     = buf_sel_q;
  assign bus.iter_count  = iter_count_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.converged   = converged_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_jacobi_iter_ctrl.sv
// Scoreboard bench for jacobi_iter_ctrl with a sticky-detector model answering each sweep.
module tb_jacobi_iter_ctrl;

  localparam int unsigned ITER_W       = 8;
  localparam int unsigned MAX_ITER     = 4;
  localparam int unsigned FLUSH_CYCLES = 3;
  localparam int unsigned DONE_DLY     = 10;
  localparam int unsigned GAP          = DONE_DLY + 1 + FLUSH_CYCLES + 1;

  typedef struct {
    int cnt;
    bit conv;
    bit tmo;
    bit bsel;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic clock    = 1'b0;
  logic reset;

  jacobi_iter_ctrl_if #(.ITER_W(ITER_W)) bus ();

  jacobi_iter_ctrl #(
    .ITER_W(ITER_W),
    .MAX_ITER(MAX_ITER),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.calc_enable, bus.sweep_start, bus.buf_sel, bus.iter_count,
                bus.busy, bus.done, bus.converged, bus.timeout});
  endfunction

  // One solve; detector answers DONE_DLY cycles after each sweep_start and drops
  // iter_done the cycle after it has seen calc_enable low.
  task automatic run_solve(input int conv_at, input int abort_after, input int reset_at,
                           input bit restart);
    exp_t e, got_e;
    int   n, nsw, ndone, last, cd, iter_n, stray;
    bit   ce_prev, fin;
    nsw = 0; ndone = 0; last = 0; cd = 0; iter_n = 0; ce_prev = 1'b1; fin = 1'b0;
    n      = (conv_at != 0 && conv_at <= int'(MAX_ITER)) ? conv_at : int'(MAX_ITER);
    e.cnt  = n;
    e.conv = (conv_at != 0 && conv_at <= int'(MAX_ITER));
    e.tmo  = !e.conv;
    e.bsel = (n % 2) != 0;
    if (abort_after == 0 && reset_at == 0) sb_q.push_back(e);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("launch_busy", 32'(bus.busy), 1);
    chk("launch_cnt", 32'(bus.iter_count), 0);

    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (cyc > 0) step();
      bus.start = 1'b0;
      if (bus.iter_done && !ce_prev) begin
        bus.iter_done = 1'b0;
        bus.conv_ok   = 1'b0;
      end
      ce_prev = bus.calc_enable;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          iter_n++;
          bus.iter_done = 1'b1;
          bus.conv_ok   = (iter_n == conv_at);
        end else if (restart && cd == 5) begin
          bus.start = 1'b1;
        end
      end
      if (cyc == 0) chk("launch_sweep", 32'(bus.sweep_start), 1);
      if (bus.sweep_start) begin
        nsw++;
        chk("sweep_buf", 32'(bus.buf_sel), 32'((nsw - 1) % 2));
        if (nsw > 1) chk("sweep_gap", 32'(cyc - last), GAP);
        last = cyc;
        cd   = DONE_DLY;
      end
      if (abort_after != 0 && int'(bus.iter_count) == abort_after && bus.busy &&
          !bus.calc_enable) begin
        bus.abort = 1'b1;
        step();
        bus.abort     = 1'b0;
        bus.iter_done = 1'b0;
        bus.conv_ok   = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_ce", 32'(bus.calc_enable), 0);
        chk("abort_cnt", 32'(bus.iter_count), 32'(abort_after));
        chk("abort_buf", 32'(bus.buf_sel), 32'(abort_after % 2));
        chk("abort_flags", 32'({bus.converged, bus.timeout}), 0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
          if (bus.done || bus.sweep_start || bus.busy) stray++;
          step();
        end
        chk("abort_quiet", 32'(stray), 0);
        fin = 1'b1;
      end else if (reset_at != 0 && int'(bus.iter_count) == reset_at && bus.calc_enable &&
                   !bus.sweep_start) begin
        reset = 1'b1;
        step();
        chk("midrun_reset_outs", all_outs(), 0);
        reset         = 1'b0;
        bus.iter_done = 1'b0;
        bus.conv_ok   = 1'b0;
        step();
        fin = 1'b1;
      end else if (bus.done) begin
        ndone++;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(sb_q.size()), 1);
        end else begin
          got_e = sb_q.pop_front();
          chk("done_cnt", 32'(bus.iter_count), 32'(got_e.cnt));
          chk("done_conv", 32'(bus.converged), 32'(got_e.conv));
          chk("done_tmo", 32'(bus.timeout), 32'(got_e.tmo));
          chk("done_buf", 32'(bus.buf_sel), 32'(got_e.bsel));
        end
        step();
        chk("done_pulse", 32'(bus.done), 0);
        chk("done_busy", 32'(bus.busy), 0);
        chk("conv_hold", 32'(bus.converged), 32'(e.conv));
        fin = 1'b1;
      end
    end
    if (!fin) chk("solve_bound", 0, 1);
    if (abort_after == 0 && reset_at == 0) begin
      chk("sweeps", 32'(nsw), 32'(n));
      chk("dones", 32'(ndone), 1);
    end
  endtask

  task automatic idle_noise(input int held_cnt);
    int stray;
    stray = 0;
    bus.iter_done = 1'b1;
    bus.conv_ok   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.sweep_start || bus.busy || bus.calc_enable) stray++;
    end
    bus.iter_done = 1'b0;
    bus.conv_ok   = 1'b0;
    chk("idle_noise_quiet", 32'(stray), 0);
    chk("idle_noise_cnt", 32'(bus.iter_count), 32'(held_cnt));
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 32'(bus.busy), 0);
    chk("start_abort_sweep", 32'(bus.sweep_start), 0);
    step();
    chk("start_abort_cnt", 32'(bus.iter_count), 32'(held_cnt));
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.iter_done = 1'b0;
    bus.conv_ok   = 1'b0;
    repeat (3) step();
    chk("reset_outs", all_outs(), 0);
    reset = 1'b0;
    step();
    chk("post_reset_outs", all_outs(), 0);

    run_solve(0, 0, 0, 1'b1);
    idle_noise(int'(MAX_ITER));
    run_solve(2, 0, 0, 1'b0);
    run_solve(4, 0, 0, 1'b0);
    run_solve(0, 1, 0, 1'b0);
    run_solve(3, 0, 0, 1'b0);
    run_solve(0, 0, 2, 1'b0);
    run_solve(1, 0, 0, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jacobi_iter_ctrl.md
Name: jacobi_iter_ctrl

Overview:
Iteration sequencer that consumes iter_done from the iteration-completion detector and drives the next Jacobi sweep. Launches sweeps, gates the detector through calc_enable, and counts iterations. Toggles the X ping-pong buffer select between sweeps and terminates on convergence, iteration limit or abort. Sits between the top-level host handshake and the sweep datapath / address generator.

Parameters:
ITER_W, 8, width of iteration counter
MAX_ITER, 100, iteration limit (1..2^ITER_W-1)
FLUSH_CYCLES, 14, idle gap between sweeps for pipeline drain and detector clear (>=2)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  pulse: begin solve (ignored while busy)
abort  in  1  level/pulse: terminate solve
iter_done  in  1  sticky iteration-complete flag from detector
conv_ok  in  1  convergence flag, valid whenever iter_done=1
calc_enable  out  1  enable to detector; low clears iter_done
sweep_start  out  1  one-cycle pulse: start address generator sweep
buf_sel  out  1  X buffer select (read bank); write bank = ~buf_sel
iter_count  out  ITER_W  completed iterations this solve
busy  out  1  solve in progress
done  out  1  one-cycle pulse at solve end
converged  out  1  solve ended by conv_ok (held until next start)
timeout  out  1  solve ended by MAX_ITER (held until next start)

Behaviour:
- All outputs registered. Reset: state IDLE, all outputs 0, flush counter 0.
- States: IDLE, LAUNCH, RUN, CHECK, FLUSH, FINISH.
- IDLE: start=1 -> LAUNCH; clears iter_count, buf_sel, converged, timeout on the same edge.
- LAUNCH (1 cycle): sweep_start=1, calc_enable=1, busy=1 -> RUN.
- RUN: calc_enable=1; wait for iter_done=1 -> CHECK. No internal timeout.
- CHECK (1 cycle): iter_count+1 registered, buf_sel toggled, calc_enable=0.
  - conv_ok=1 -> FINISH, converged=1.
  - else if iter_count+1 == MAX_ITER -> FINISH, timeout=1.
  - else -> FLUSH, flush counter loaded with FLUSH_CYCLES-1.
  - conv_ok and limit in the same CHECK: converged=1, timeout=0 (convergence wins).
- FLUSH: calc_enable=0; counter decrements; at 0 -> LAUNCH. The FLUSH_CYCLES>=2 floor guarantees the detector sees enable low and drops iter_done before re-enable.
- FINISH (1 cycle): done=1, busy falls on the following edge -> IDLE. calc_enable stays 0.
- busy=1 in every state except IDLE. It is registered, so it goes high one cycle after start is sampled.
- Latencies:
  - start sampled at edge N: sweep_start high for the cycle after N.
  - iter_done sampled in RUN at edge M: iter_count/buf_sel update at M+1.
  - next sweep_start follows FLUSH_CYCLES cycles after CHECK.
- abort=1 in any non-IDLE state: next state IDLE, calc_enable=0, busy=0, no done pulse. iter_count/buf_sel hold; converged/timeout unchanged. abort has priority over all other transitions, including CHECK decisions.
- start while busy: ignored. start and abort together in IDLE: abort wins, stays IDLE.
- iter_done outside RUN: ignored (stale sticky value).
- iter_count never wraps: the MAX_ITER bound stops it first.
- Reset mid-solve: immediate return to reset values on that edge.

Test Plan:
- MAX_ITER=4, FLUSH=3, conv_ok=0. start; assert iter_done 10 cycles after each sweep_start, deasserting once calc_enable is low -> 4 sweep_start pulses spaced 10+1+3+1 cycles, buf_sel sequence 0,1,0,1,0, iter_count 4, timeout=1, converged=0, single done pulse.
- Same, conv_ok=1 on 2nd iter_done -> iter_count=2, converged=1, timeout=0, buf_sel=0, done once, no 3rd sweep_start.
- conv_ok=1 on the 4th (limit) iteration -> converged=1, timeout=0.
- abort asserted in FLUSH after iteration 1 -> IDLE next cycle, busy=0, no done, iter_count=1, buf_sel=1. Subsequent start clears count/buf_sel and runs normally.
- start re-pulsed during RUN, and iter_done held high in IDLE -> no effect on state, count or sweep_start.
- reset asserted in RUN with iter_count=2 -> all outputs 0 on the next edge. start after reset release -> sweep_start one cycle after start is sampled.
